y86_regfile_2w2r: RTL and testbench

Parametrised two-write, two-read register file for the pipelined Y86-64 core, instanced in decode/write-back. Decode reads srcA/srcB combinationally. Write-back commits the E-port (valE) and M-port (valM) results on the rising clock edge with a fixed collision priority. RNONE (0xF) suppresses both reads and writes. An optional bypass forwards same-cycle write data to the read ports.

---
 rtl/y86_pkg.sv | 11 +
 rtl/regfile_read_port.sv | 31 +++
 rtl/y86_regfile_2w2r.sv | 53 +++++
 tb/tb_y86_regfile_2w2r.sv | 110 +++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 register ids, instruction codes and datapath types.
package y86_pkg;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP = 4'h4;
  typedef logic [3:0] reg_id_t;
  typedef logic [63:0] word_t;
  typedef enum logic [3:0] {
    I_HALT, I_NOP, I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
    I_OPQ, I_JXX, I_CALL, I_RET, I_PUSHQ, I_POPQ
  } icode_t;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port; ids >= NREGS read as 0.
// REGFILE_BYPASS_EN forwards same-cycle committing write data, M over E.
module regfile_read_port import y86_pkg::*; #(
  parameter int W = 64,
  parameter int NREGS = 15,
  parameter int IDW = 4
) (
  input  logic [NREGS*W-1:0] regs,
  input  logic [IDW-1:0]     src,
  input  logic [IDW-1:0]     dst_e,
  input  logic [IDW-1:0]     dst_m,
  input  logic               we_e,
  input  logic               we_m,
  input  logic [W-1:0]       val_e,
  input  logic [W-1:0]       val_m,
  output logic [W-1:0]       val
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic hit;
  logic [W-1:0] stored;
  assign hit = int'(src) < NREGS;
  assign stored = hit ? regs[int'(src)*W +: W] : '0;
  always_comb
    val = !hit ? '0 :
          (BYPASS && we_m && src == dst_m) ? val_m :
          (BYPASS && we_e && src == dst_e) ? val_e : stored;
endmodule

// File: rtl/y86_regfile_2w2r.sv
// y86_regfile_2w2r: two-write (E, M) two-read Y86-64 register file with saturating write counter.
// Optional same-cycle read forwarding under macro REGFILE_BYPASS_EN.
module y86_regfile_2w2r import y86_pkg::*; #(
  parameter int W = 64,
  parameter int NREGS = 15,
  parameter int IDW = 4,
  parameter int INIT_IDX = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDW-1:0]     srcA,
  input  logic [IDW-1:0]     srcB,
  output logic [W-1:0]       valA,
  output logic [W-1:0]       valB,
  input  logic [IDW-1:0]     dstE,
  input  logic [W-1:0]       valE,
  input  logic [IDW-1:0]     dstM,
  input  logic [W-1:0]       valM,
  input  logic               wr_stall,
  output logic [NREGS*W-1:0] regs_flat,
  output logic [15:0]        wr_cnt
);
  logic [W-1:0] regs [NREGS];
  logic we_e, we_m;
  logic [1:0] inc;
  logic [16:0] cnt_sum;
  assign we_e = !wr_stall && int'(dstE) < NREGS;
  assign we_m = !wr_stall && int'(dstM) < NREGS;
  // a colliding E/M pair is one architectural write
  assign inc = (we_e && we_m && dstE == dstM) ? 2'd1 : {1'b0, we_e} + {1'b0, we_m};
  assign cnt_sum = {1'b0, wr_cnt} + 17'(inc);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= (INIT_IDX != 0) ? W'(i) : '0;
      wr_cnt <= '0;
    end else begin
      if (we_e) regs[dstE] <= valE;
      if (we_m) regs[dstM] <= valM;
      wr_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end
  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*W +: W] = regs[g];
  end
  regfile_read_port #(.W(W), .NREGS(NREGS), .IDW(IDW)) u_rd_a (
    .regs(regs_flat), .src(srcA), .dst_e(dstE), .dst_m(dstM), .we_e(we_e), .we_m(we_m),
    .val_e(valE), .val_m(valM), .val(valA)
  );
  regfile_read_port #(.W(W), .NREGS(NREGS), .IDW(IDW)) u_rd_b (
    .regs(regs_flat), .src(srcB), .dst_e(dstE), .dst_m(dstM), .we_e(we_e), .we_m(we_m),
    .val_e(valE), .val_m(valM), .val(valB)
  );
endmodule

// File: tb/tb_y86_regfile_2w2r.sv
// tb_y86_regfile_2w2r: randomized + directed scoreboard bench against an array reference model.
module tb_y86_regfile_2w2r;
  import y86_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] srcA = 4'hF, srcB = 4'hF, dstE = 4'hF, dstM = 4'hF;
  logic [63:0] valE = '0, valM = '0;
  logic wr_stall = 1'b0;
  logic [63:0] valA, valB;
  logic [15*64-1:0] regs_flat;
  logic [15:0] wr_cnt;
  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [15*64-1:0] flat;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];
  logic [63:0] mdl [15];
  int mcnt = 0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  y86_regfile_2w2r dut (
    .clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM), .wr_stall(wr_stall),
    .regs_flat(regs_flat), .wr_cnt(wr_cnt)
  );
  function automatic logic [63:0] rd(input logic [3:0] s);
    bit e = !wr_stall && dstE < 4'd15;
    bit m = !wr_stall && dstM < 4'd15;
    if (s >= 4'd15) return '0;
`ifdef REGFILE_BYPASS_EN
    if (m && s == dstM) return valM;
    if (e && s == dstE) return valE;
`else
    if (e && m) return mdl[s];
`endif
    return mdl[s];
  endfunction
  task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b, input logic [3:0] de,
                      input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm, input logic st);
    exp_t x;
    bit e, m;
    int n;
    @(negedge clk);
    rst_n = r; srcA = a; srcB = b; dstE = de; valE = ve; dstM = dm; valM = vm; wr_stall = st;
    x.a = rd(a);
    x.b = rd(b);
    for (int i = 0; i < 15; i++) x.flat[i*64 +: 64] = mdl[i];
    x.cnt = 16'(mcnt);
    q.push_back(x);
    @(posedge clk);
    e = !st && de < 4'd15;
    m = !st && dm < 4'd15;
    if (!r) begin
      for (int i = 0; i < 15; i++) mdl[i] = 64'(i);
      mcnt = 0;
    end else begin
      n = 0;
      if (e) begin mdl[de] = ve; n++; end
      if (m) begin mdl[dm] = vm; if (!(e && de == dm)) n++; end
      mcnt = (mcnt + n > 65535) ? 65535 : mcnt + n;
    end
  endtask
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        x = q.pop_front();
        tests += 4;
        if (valA !== x.a) begin fails++; $display("FAIL valA got %h want %h t=%0t", valA, x.a, $time); end
        if (valB !== x.b) begin fails++; $display("FAIL valB got %h want %h t=%0t", valB, x.b, $time); end
        if (regs_flat !== x.flat) begin fails++; $display("FAIL regs_flat differs t=%0t", $time); end
        if (wr_cnt !== x.cnt) begin fails++; $display("FAIL wr_cnt got %0d want %0d t=%0t", wr_cnt, x.cnt, $time); end
      end
    end
  end
  initial begin
    for (int i = 0; i < 15; i++) mdl[i] = 64'(i);
    repeat (2) @(posedge clk);
    step(1'b0, RRSP, RNONE, RNONE, 0, RNONE, 0, 1'b0);
    step(1'b1, RRSP, RNONE, 4'd3, 64'hDEAD, RNONE, 0, 1'b0);
    step(1'b1, 4'd3, 4'd14, RNONE, 0, RNONE, 0, 1'b0);
    step(1'b1, RRSP, 4'd3, RRSP, 64'h100, RRSP, 64'h200, 1'b0);
    step(1'b1, RRSP, 4'd2, 4'd2, 64'h55, RNONE, 0, 1'b0);
    step(1'b1, 4'd2, 4'd5, 4'd5, 64'h77, RNONE, 0, 1'b1);
    step(1'b1, 4'd5, 4'd1, RNONE, 0, 4'd1, 64'hFF, 1'b0);
    step(1'b0, 4'd1, 4'd5, RNONE, 0, 4'd1, 64'hFF, 1'b0);
    step(1'b1, 4'd1, 4'd9, 4'd9, 64'hA5A5, 4'd9, 64'h5A5A, 1'b1);
    for (int k = 0; k < 400; k++)
      step(($urandom_range(0, 39) != 0), 4'($urandom), 4'($urandom), 4'($urandom),
           {$urandom, $urandom}, 4'($urandom), {$urandom, $urandom}, ($urandom_range(0, 4) == 0));
    step(1'b0, 0, 0, RNONE, 0, RNONE, 0, 1'b0);
    while (mcnt < 65535)
      step(1'b1, 4'($urandom), 4'($urandom), 4'($urandom_range(0, 6)), {$urandom, $urandom},
           4'($urandom_range(7, 14)), {$urandom, $urandom}, 1'b0);
    for (int k = 0; k < 4; k++)
      step(1'b1, 4'($urandom), 4'($urandom), 4'd0, {$urandom, $urandom}, 4'd1, {$urandom, $urandom}, 1'b0);
    step(1'b1, 0, 1, RNONE, 0, RNONE, 0, 1'b0);
    @(negedge clk);
    #3;
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL queue_drain got %0d want 0", q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
